alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Command front-end for the signed structural ALU. It accepts one operation at a time over a valid/ready handshake and registers the operands. It decodes the 4-bit function code into a one-hot enable for exactly one execution unit (arithmetic, logic, compare, shift) and holds that enable until the unit raises its flag. It then captures the unit result and presents it downstream over a second valid/ready handshake.

Parameters:
DATA_WIDTH, 16, width of signed operands A/B driven to all units
OUT_WIDTH, 16, width of each unit result bus and of res_data
TIMEOUT_CYCLES, 8, max cycles in EXEC waiting for the selected flag before error (>=2)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-low
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept command
cmd_a  input  DATA_WIDTH  signed operand A
cmd_b  input  DATA_WIDTH  signed operand B
cmd_fun  input  4  [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift); [1:0] unit op
unit_a  output  DATA_WIDTH  registered operand A to all units
unit_b  output  DATA_WIDTH  registered operand B to all units
unit_fun  output  2  registered cmd_fun[1:0] to all units
arith_en / logic_en / cmp_en / shift_en  output  1 each  unit enables, at most one high
arith_out / logic_out / cmp_out / shift_out  input  OUT_WIDTH each  unit results
arith_flag / logic_flag / cmp_flag / shift_flag  input  1 each  unit result-valid flags
res_valid  output  1  result available
res_ready  input  1  downstream accepts result
res_data  output  OUT_WIDTH  captured result
res_fun  output  4  function code of the result
res_err  output  1  timeout occurred; res_data is 0
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, RST=0): state IDLE. All registers and outputs are 0 except cmd_ready=1: unit_a/b/fun, res_data/fun/err, res_valid, enables, busy, timeout counter. Applies mid-operation: enables drop immediately, and any pending command or result is discarded.
- States: IDLE, EXEC, RESP. The state is registered; enables, cmd_ready, res_valid and busy are decoded from state only, so they are glitch-free and carry no input-to-output combinational path.
- IDLE: cmd_ready=1.
  - On cmd_valid: latch cmd_a, cmd_b, cmd_fun into unit_a, unit_b, unit_fun and the internal fun register.
  - Clear the counter and go to EXEC.
- EXEC: the enable selected by fun[3:2] is high; the other three enables are low. Each cycle:
  - If the selected flag is 1: res_data <= selected _out, res_err <= 0, res_fun <= fun, go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1: res_data <= 0, res_err <= 1, go to RESP.
  - Else increment the counter.
  - Flags from non-selected units are ignored.
  - Flag and timeout in the same cycle: the flag wins.
- RESP: res_valid=1 and the result registers are held stable. On res_ready go to IDLE; cmd_ready rises the following cycle. While res_ready=0, hold indefinitely.
- Timing with a registered unit (1-cycle): cmd accepted at edge t0 -> enable high in cycle t0+1 -> flag high in t0+2 -> captured at the end of t0+2 -> res_valid in t0+3. Issue-to-result is 3 cycles, and the minimum command spacing is 4 cycles with res_ready tied high.
- The enable stays asserted through the capture cycle. This matters because units zero their outputs when the enable drops.
- unit_a, unit_b and unit_fun hold their last values after completion; they change only on command accept.
- cmd_valid with cmd_ready=0 is ignored; no buffering. Upstream must hold the command until the handshake completes.
- Operands pass through unmodified; no width conversion or sign handling in this block.

Decomposition:
- Shared package alu_pkg: unit-select encodings (UNIT_ARITH=2'b00, UNIT_LOGIC=2'b01, UNIT_CMP=2'b10, UNIT_SHIFT=2'b11), the state encoding, and the function-code field positions.
- One natural sub-module, alu_unit_decoder: combinational 2-bit select plus active input -> 4-bit one-hot enable, also used to mux the selected flag and out.

Test Plan:
- Logic AND: cmd_a=16'h00FF, cmd_b=16'h0F0F, cmd_fun=4'b0100, logic unit model with 1-cycle latency -> logic_en high in cycles t0+1..t0+2 only; res_valid at t0+3 with res_data=16'h000F, res_fun=4'b0100, res_err=0.
- Backpressure: complete a command with res_ready=0 for 5 cycles -> res_valid and res_data stable, cmd_ready=0, second cmd_valid ignored. res_ready=1 -> IDLE next cycle, second command accepted.
- Timeout: cmd_fun=4'b1000 with cmp_flag tied 0 and cmp_out=16'hBEEF -> cmp_en high exactly 8 cycles; res_err=1, res_data=0. Also check the flag-on-last-cycle case gives res_err=0.
- Wrong-unit flag: shift command while logic_flag=1 and shift_flag delayed 3 cycles -> result taken from shift_out only, res_valid at t0+5.
- Async reset in EXEC: assert RST=0 mid-cycle -> all enables, busy and res_valid go 0 without a clock edge. After release, cmd_ready=1 and a new command runs normally.
- Back-to-back: four commands, one per unit, res_ready=1 -> exactly one enable per command, results in order, 4-cycle spacing, signed operand -16'sd5 forwarded to unit_a unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue controller: unit selects, FSM states and
// function-code field positions.
package alu_pkg;

    typedef logic [1:0] unit_sel_t;

    localparam unit_sel_t UNIT_ARITH = 2'b00;
    localparam unit_sel_t UNIT_LOGIC = 2'b01;
    localparam unit_sel_t UNIT_CMP   = 2'b10;
    localparam unit_sel_t UNIT_SHIFT = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    localparam int unsigned FUN_UNIT_HI = 3;
    localparam int unsigned FUN_UNIT_LO = 2;
    localparam int unsigned FUN_OP_HI   = 1;
    localparam int unsigned FUN_OP_LO   = 0;

    function automatic unit_sel_t fun_unit(input logic [3:0] fun);
        return fun[FUN_UNIT_HI:FUN_UNIT_LO];
    endfunction

    function automatic logic [1:0] fun_op(input logic [3:0] fun);
        return fun[FUN_OP_HI:FUN_OP_LO];
    endfunction

endpackage

// File: rtl/alu_unit_decoder.sv
// Select -> one-hot unit enable, plus mux of the selected unit's flag and result.
module alu_unit_decoder
    import alu_pkg::*;
#(
    parameter int unsigned OUT_WIDTH = 16
) (
    input  logic [1:0]           sel,
    input  logic                 active,
    input  logic [3:0]           flags,
    input  logic [OUT_WIDTH-1:0] arith_out,
    input  logic [OUT_WIDTH-1:0] logic_out,
    input  logic [OUT_WIDTH-1:0] cmp_out,
    input  logic [OUT_WIDTH-1:0] shift_out,
    output logic [3:0]           en,
    output logic                 flag,
    output logic [OUT_WIDTH-1:0] out
);

    always_comb begin
        en   = 4'b0000;
        flag = 1'b0;
        out  = '0;
        unique case (sel)
            UNIT_ARITH: begin
                en[0] = active;
                flag  = flags[0];
                out   = arith_out;
            end
            UNIT_LOGIC: begin
                en[1] = active;
                flag  = flags[1];
                out   = logic_out;
            end
            UNIT_CMP: begin
                en[2] = active;
                flag  = flags[2];
                out   = cmp_out;
            end
            UNIT_SHIFT: begin
                en[3] = active;
                flag  = flags[3];
                out   = shift_out;
            end
            default: begin
                en   = 4'b0000;
                flag = 1'b0;
                out  = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command front-end for the structural ALU: accepts one operation, enables a single
// execution unit until its flag, then presents the captured result downstream.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned OUT_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    input  logic [3:0]            cmd_fun,
    output logic [DATA_WIDTH-1:0] unit_a,
    output logic [DATA_WIDTH-1:0] unit_b,
    output logic [1:0]            unit_fun,
    output logic                  arith_en,
    output logic                  logic_en,
    output logic                  cmp_en,
    output logic                  shift_en,
    input  logic [OUT_WIDTH-1:0]  arith_out,
    input  logic [OUT_WIDTH-1:0]  logic_out,
    input  logic [OUT_WIDTH-1:0]  cmp_out,
    input  logic [OUT_WIDTH-1:0]  shift_out,
    input  logic                  arith_flag,
    input  logic                  logic_flag,
    input  logic                  cmp_flag,
    input  logic                  shift_flag,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [OUT_WIDTH-1:0]  res_data,
    output logic [3:0]            res_fun,
    output logic                  res_err,
    output logic                  busy
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]           state_q, state_d;
    logic [3:0]           fun_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [DATA_WIDTH-1:0] unit_a_q, unit_b_q;
    logic [1:0]           unit_fun_q;
    logic [OUT_WIDTH-1:0] res_data_q;
    logic [3:0]           res_fun_q;
    logic                 res_err_q;

    logic                 in_idle, in_exec, in_resp;
    logic [3:0]           en;
    logic                 sel_flag;
    logic [OUT_WIDTH-1:0] sel_out;
    logic                 accept, take_flag, take_timeout;

    assign in_idle = (state_q == ST_IDLE);
    assign in_exec = (state_q == ST_EXEC);
    assign in_resp = (state_q == ST_RESP);

    // Enable depends only on registered state and fun, so it stays high through
    // the capture cycle and drops immediately on async reset.
    alu_unit_decoder #(
        .OUT_WIDTH (OUT_WIDTH)
    ) u_decoder (
        .sel       (fun_unit(fun_q)),
        .active    (in_exec),
        .flags     ({shift_flag, cmp_flag, logic_flag, arith_flag}),
        .arith_out (arith_out),
        .logic_out (logic_out),
        .cmp_out   (cmp_out),
        .shift_out (shift_out),
        .en        (en),
        .flag      (sel_flag),
        .out       (sel_out)
    );

    assign accept       = in_idle && cmd_valid;
    assign take_flag    = in_exec && sel_flag;
    assign take_timeout = in_exec && !sel_flag && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) state_d = ST_EXEC;
            ST_EXEC: if (take_flag || take_timeout) state_d = ST_RESP;
            ST_RESP: if (res_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            fun_q      <= 4'b0000;
            cnt_q      <= '0;
            unit_a_q   <= '0;
            unit_b_q   <= '0;
            unit_fun_q <= 2'b00;
            res_data_q <= '0;
            res_fun_q  <= 4'b0000;
            res_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                unit_a_q   <= cmd_a;
                unit_b_q   <= cmd_b;
                unit_fun_q <= fun_op(cmd_fun);
                fun_q      <= cmd_fun;
                cnt_q      <= '0;
            end
            if (take_flag) begin
                res_data_q <= sel_out;
                res_err_q  <= 1'b0;
                res_fun_q  <= fun_q;
            end else if (take_timeout) begin
                res_data_q <= '0;
                res_err_q  <= 1'b1;
                res_fun_q  <= fun_q;
            end else if (in_exec) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign cmd_ready = in_idle;
    assign res_valid = in_resp;
    assign busy      = !in_idle;
    assign arith_en  = en[0];
    assign logic_en  = en[1];
    assign cmp_en    = en[2];
    assign shift_en  = en[3];
    assign unit_a    = unit_a_q;
    assign unit_b    = unit_b_q;
    assign unit_fun  = unit_fun_q;
    assign res_data  = res_data_q;
    assign res_fun   = res_fun_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with simple latency-programmable unit models.
module tb_alu_issue_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_a = '0, cmd_b = '0;
    logic [3:0]  cmd_fun = '0;
    logic [15:0] unit_a, unit_b;
    logic [1:0]  unit_fun;
    logic        arith_en, logic_en, cmp_en, shift_en;
    logic [15:0] arith_out, logic_out, cmp_out, shift_out;
    logic        arith_flag, logic_flag, cmp_flag, shift_flag;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [15:0] res_data;
    logic [3:0]  res_fun;
    logic        res_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  fun;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    alu_issue_ctrl #(
        .DATA_WIDTH     (16),
        .OUT_WIDTH      (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_fun    (cmd_fun),
        .unit_a     (unit_a),
        .unit_b     (unit_b),
        .unit_fun   (unit_fun),
        .arith_en   (arith_en),
        .logic_en   (logic_en),
        .cmp_en     (cmp_en),
        .shift_en   (shift_en),
        .arith_out  (arith_out),
        .logic_out  (logic_out),
        .cmp_out    (cmp_out),
        .shift_out  (shift_out),
        .arith_flag (arith_flag),
        .logic_flag (logic_flag),
        .cmp_flag   (cmp_flag),
        .shift_flag (shift_flag),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_fun    (res_fun),
        .res_err    (res_err),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    // Unit models: result and flag registered, flag rises lat cycles after enable.
    logic [3:0]  en_v;
    logic [15:0] u_out [4];
    logic        u_flag [4];
    int          ecnt [4];
    int          lat [4];
    logic        cmp_kill = 1'b0, cmp_force_out = 1'b0, logic_force = 1'b0;

    assign en_v = {shift_en, cmp_en, logic_en, arith_en};

    function automatic logic [15:0] ufunc(int u, logic [15:0] a, logic [15:0] b,
                                          logic [1:0] f);
        logic signed [15:0] sa, sb;
        sa = a;
        sb = b;
        case (u)
            0: return (f == 2'b01) ? a - b : a + b;
            1: case (f)
                   2'b00: return a & b;
                   2'b01: return a | b;
                   2'b10: return a ^ b;
                   default: return ~a;
               endcase
            2: case (f)
                   2'b00: return {15'd0, sa < sb};
                   2'b01: return {15'd0, a == b};
                   default: return {15'd0, sa > sb};
               endcase
            default: case (f)
                   2'b00: return a << b[3:0];
                   2'b01: return sa >>> b[3:0];
                   default: return a >> b[3:0];
               endcase
        endcase
    endfunction

    initial begin
        for (int u = 0; u < 4; u++) begin
            u_out[u]  = '0;
            u_flag[u] = 1'b0;
            ecnt[u]   = 0;
            lat[u]    = 1;
        end
    end

    always @(posedge CLK) begin
        for (int u = 0; u < 4; u++) begin
            if (en_v[u]) begin
                ecnt[u]   <= ecnt[u] + 1;
                u_flag[u] <= (ecnt[u] + 1 >= lat[u]);
                u_out[u]  <= ufunc(u, unit_a, unit_b, unit_fun);
            end else begin
                ecnt[u]   <= 0;
                u_flag[u] <= 1'b0;
                u_out[u]  <= '0;
            end
        end
    end

    assign arith_out  = u_out[0];
    assign logic_out  = u_out[1];
    assign cmp_out    = cmp_force_out ? 16'hBEEF : u_out[2];
    assign shift_out  = u_out[3];
    assign arith_flag = u_flag[0];
    assign logic_flag = logic_force ? 1'b1 : u_flag[1];
    assign cmp_flag   = cmp_kill ? 1'b0 : u_flag[2];
    assign shift_flag = u_flag[3];

    // Monitor: compare each accepted result against the head of the queue.
    always @(negedge CLK) begin
        if (RST && res_valid && res_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result actual data=%h required none", res_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (res_data !== e.data || res_fun !== e.fun || res_err !== e.err) begin
                    errors++;
                    $display("FAIL result actual data=%h fun=%b err=%b required data=%h fun=%b err=%b",
                             res_data, res_fun, res_err, e.data, e.fun, e.err);
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(logic [15:0] d, logic [3:0] f, logic e);
        exp_t x;
        x.data = d;
        x.fun  = f;
        x.err  = e;
        exp_q.push_back(x);
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Returns just after the accepting edge, i.e. in cycle t0+1.
    task automatic issue(logic [15:0] a, logic [15:0] b, logic [3:0] f);
        int n;
        n = 0;
        cmd_a     = a;
        cmd_b     = b;
        cmd_fun   = f;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            step(1);
            n++;
        end
        if (!cmd_ready) chk("issue_ready_timeout", 32'd0, 32'd1);
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!res_valid && n < 40) begin
            step(1);
            n++;
        end
        if (!res_valid) chk("wait_valid_timeout", 32'd0, 32'd1);
    endtask

    longint t_prev, t_now;
    int     en_cnt;

    initial begin
        // Reset state
        #12;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_enables", en_v, 0);
        chk("rst_unit_a", unit_a, 0);
        chk("rst_res_data", res_data, 0);
        #5 RST = 1'b1;
        step(2);

        // Logic AND, 1-cycle unit
        push_exp(16'h000F, 4'b0100, 1'b0);
        issue(16'h00FF, 16'h0F0F, 4'b0100);
        chk("and_en_t1", en_v, 4'b0010);
        chk("and_busy", busy, 1);
        step(1);
        chk("and_en_t2", en_v, 4'b0010);
        chk("and_valid_t2", res_valid, 0);
        step(1);
        chk("and_en_t3", en_v, 4'b0000);
        chk("and_valid_t3", res_valid, 1);
        chk("and_data_t3", res_data, 16'h000F);
        step(1);

        // Backpressure
        res_ready = 1'b0;
        push_exp(16'h0007, 4'b0000, 1'b0);
        issue(16'h0003, 16'h0004, 4'b0000);
        wait_valid();
        push_exp(16'h1112, 4'b0010, 1'b0);
        cmd_a     = 16'h1111;
        cmd_b     = 16'h0001;
        cmd_fun   = 4'b0010;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", res_valid, 1);
            chk("bp_data", res_data, 16'h0007);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_unit_a", unit_a, 16'h0003);
            step(1);
        end
        res_ready = 1'b1;
        step(1);
        chk("bp_idle_ready", cmd_ready, 1);
        chk("bp_idle_busy", busy, 0);
        step(1);
        cmd_valid = 1'b0;
        chk("bp_second_a", unit_a, 16'h1111);
        chk("bp_second_en", en_v, 4'b0001);
        wait_valid();
        step(1);

        // Timeout: compare unit never flags
        cmp_kill      = 1'b1;
        cmp_force_out = 1'b1;
        push_exp(16'h0000, 4'b1000, 1'b1);
        issue(16'h0001, 16'h0002, 4'b1000);
        en_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            en_cnt += int'(cmp_en);
            step(1);
        end
        chk("to_cmp_en_cycles", en_cnt, 8);
        cmp_kill      = 1'b0;
        cmp_force_out = 1'b0;

        // Flag arrives in the last allowed cycle
        lat[2] = 7;
        push_exp(16'h0001, 4'b1000, 1'b0);
        issue(16'hFFFD, 16'h0002, 4'b1000);
        step(7);
        chk("last_valid_t8", res_valid, 0);
        step(1);
        chk("last_valid_t9", res_valid, 1);
        chk("last_err", res_err, 0);
        lat[2] = 1;
        step(1);

        // Wrong-unit flag ignored; shift unit 3-cycle latency
        logic_force = 1'b1;
        lat[3]      = 3;
        push_exp(16'h0030, 4'b1100, 1'b0);
        issue(16'h0003, 16'h0004, 4'b1100);
        chk("wu_en_t1", en_v, 4'b1000);
        step(3);
        chk("wu_valid_t4", res_valid, 0);
        chk("wu_logic_en", logic_en, 0);
        step(1);
        chk("wu_valid_t5", res_valid, 1);
        chk("wu_data", res_data, 16'h0030);
        logic_force = 1'b0;
        lat[3]      = 1;
        step(1);

        // Async reset while in EXEC
        lat[0] = 5;
        issue(16'h0001, 16'h0001, 4'b0000);
        chk("ar_en_before", arith_en, 1);
        #2 RST = 1'b0;
        #1;
        chk("ar_enables", en_v, 0);
        chk("ar_busy", busy, 0);
        chk("ar_res_valid", res_valid, 0);
        chk("ar_cmd_ready", cmd_ready, 1);
        chk("ar_unit_a", unit_a, 0);
        #3 RST = 1'b1;
        lat[0] = 1;
        step(1);
        push_exp(16'h000B, 4'b0000, 1'b0);
        issue(16'h0005, 16'h0006, 4'b0000);
        wait_valid();
        chk("ar_after_data", res_data, 16'h000B);
        step(1);

        // Back-to-back, one per unit
        push_exp(16'hFFF8, 4'b0001, 1'b0);
        push_exp(16'h0F00, 4'b0110, 1'b0);
        push_exp(16'h0001, 4'b1001, 1'b0);
        push_exp(16'hF800, 4'b1101, 1'b0);
        issue(16'hFFFB, 16'h0003, 4'b0001);
        t_prev = $time;
        chk("b2b_unit_a_neg5", unit_a, 16'hFFFB);
        chk("b2b_en0", en_v, 4'b0001);
        issue(16'h00F0, 16'h0FF0, 4'b0110);
        t_now = $time;
        chk("b2b_en1", en_v, 4'b0010);
        chk("b2b_space1", 32'(t_now - t_prev), 32'd40);
        t_prev = t_now;
        issue(16'h1234, 16'h1234, 4'b1001);
        t_now = $time;
        chk("b2b_en2", en_v, 4'b0100);
        chk("b2b_space2", 32'(t_now - t_prev), 32'd40);
        t_prev = t_now;
        issue(16'h8000, 16'h0004, 4'b1101);
        t_now = $time;
        chk("b2b_en3", en_v, 4'b1000);
        chk("b2b_space3", 32'(t_now - t_prev), 32'd40);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
